// File: rtl/issue_scoreboard_pkg.sv
// Shared encodings for the in-order issue path: instruction function types
// and issue-controller FSM states, used by decode, issue and execute.
package issue_scoreboard_pkg;

   localparam int unsigned SB_NUM_REGS = 32;
   localparam int unsigned SB_REG_W    = 5;
   localparam int unsigned SB_CNT_W    = 6;

   typedef enum logic [1:0] {
      FT_ARITH  = 2'd0,
      FT_LDST   = 2'd1,
      FT_BRANCH = 2'd2,
      FT_FRAME  = 2'd3
   } func_type_e;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_BR_WAIT = 2'd1,
      ST_DRAIN   = 2'd2
   } issue_state_e;

endpackage

// File: rtl/issue_scoreboard_regs.sv
// Register busy bitmap with one set and one clear port per cycle, plus a
// registered population count of the bitmap.
module scoreboard_regs
   import issue_scoreboard_pkg::*;
#(
   parameter int unsigned NUM_REGS = SB_NUM_REGS,
   parameter int unsigned REG_W    = SB_REG_W,
   parameter int unsigned CNT_W    = SB_CNT_W
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_clear,
   input  logic                i_set,
   input  logic [REG_W-1:0]    i_set_idx,
   input  logic                i_clr,
   input  logic [REG_W-1:0]    i_clr_idx,
   output logic [NUM_REGS-1:0] o_busy,
   output logic [CNT_W-1:0]    o_pending
);

   logic [NUM_REGS-1:0] r_busy;
   logic [CNT_W-1:0]    r_pending;
   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_clr_mask;
   logic [NUM_REGS-1:0] w_busy_next;
   logic [CNT_W-1:0]    w_count;

   // Clearing a register that is not busy is a no-op, so stray writebacks
   // cannot underflow the count; the count is taken on the next bitmap.
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (i_set) w_set_mask[i_set_idx] = 1'b1;
      if (i_clr) w_clr_mask[i_clr_idx] = 1'b1;
      if (i_clear) w_busy_next = '0;
      else         w_busy_next = (r_busy | w_set_mask) & ~w_clr_mask;
      w_count = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         w_count = w_count + CNT_W'(w_busy_next[i]);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy    <= '0;
         r_pending <= '0;
      end else begin
         r_busy    <= w_busy_next;
         r_pending <= w_count;
      end
   end

   assign o_busy    = r_busy;
   assign o_pending = r_pending;

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue controller: RAW/WAW hazard detection on a busy bitmap,
// branch serialisation and register-frame drain before issue.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
#(
   parameter int unsigned NUM_REGS = SB_NUM_REGS,
   parameter int unsigned REG_W    = SB_REG_W,
   parameter int unsigned CNT_W    = SB_CNT_W
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                flush_i,
   input  logic                valid_i,
   input  logic [1:0]          functionType_i,
   input  logic [REG_W-1:0]    primOperand_i,
   input  logic [15:0]         secOperand_i,
   input  logic                pRead_i,
   input  logic                pWrite_i,
   input  logic                sRead_i,
   input  logic                wbValid_i,
   input  logic [REG_W-1:0]    wbReg_i,
   input  logic                branchResolved_i,
   output logic                shouldStall_o,
   output logic                issue_o,
   output logic [NUM_REGS-1:0] busy_o,
   output logic [CNT_W-1:0]    pending_o,
   output logic [1:0]          state_o
);

   issue_state_e        r_state;
   issue_state_e        w_state_next;
   func_type_e          w_ftype;
   logic [REG_W-1:0]    w_sec_idx;
   logic                w_unused_sec;
   logic [NUM_REGS-1:0] w_busy;
   logic [CNT_W-1:0]    w_pending;
   logic                w_hazard;
   logic                w_frame_block;
   logic                w_any_pending;
   logic                w_stall;
   logic                w_issue;

   assign w_ftype      = func_type_e'(functionType_i);
   assign w_sec_idx    = secOperand_i[REG_W-1:0];
   assign w_unused_sec = ^secOperand_i[15:REG_W];

   assign w_any_pending = (w_pending != '0);

   // Only the registered bitmap is consulted: a same-cycle writeback does
   // not unblock, so a retired register becomes usable one cycle later.
   assign w_hazard = (pRead_i  & w_busy[primOperand_i])
                   | (sRead_i  & w_busy[w_sec_idx])
                   | (pWrite_i & w_busy[primOperand_i]);

   assign w_frame_block = (w_ftype == FT_FRAME) & w_any_pending;

   always_comb begin
      w_state_next = r_state;
      w_stall      = 1'b0;
      w_issue      = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_stall = valid_i & (w_hazard | w_frame_block);
            w_issue = valid_i & ~w_stall & ~flush_i;
            if (valid_i & w_frame_block)
               w_state_next = ST_DRAIN;
            else if (w_issue & (w_ftype == FT_BRANCH))
               w_state_next = ST_BR_WAIT;
         end
         ST_BR_WAIT: begin
            w_stall = valid_i;
            if (branchResolved_i) w_state_next = ST_RUN;
         end
         ST_DRAIN: begin
            w_stall = valid_i;
            if (~w_any_pending & ~wbValid_i) w_state_next = ST_RUN;
         end
         default: w_state_next = ST_RUN;
      endcase
      if (flush_i) w_state_next = ST_RUN;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) r_state <= ST_RUN;
      else         r_state <= w_state_next;
   end

   scoreboard_regs #(
      .NUM_REGS (NUM_REGS),
      .REG_W    (REG_W),
      .CNT_W    (CNT_W)
   ) u_regs (
      .i_clk     (clock_i),
      .i_rst     (reset_i),
      .i_clear   (flush_i),
      .i_set     (w_issue & pWrite_i),
      .i_set_idx (primOperand_i),
      .i_clr     (wbValid_i),
      .i_clr_idx (wbReg_i),
      .o_busy    (w_busy),
      .o_pending (w_pending)
   );

   // Gated by reset so the outputs are quiet while reset is held.
   assign shouldStall_o = w_stall & ~reset_i;
   assign issue_o       = w_issue & ~reset_i;
   assign busy_o        = w_busy;
   assign pending_o     = w_pending;
   assign state_o       = r_state;

endmodule
